// File: rtl/qtpa_pkg.sv
// rtl/qtpa_pkg.sv - shared constants for the IQ0 -> scalar core instruction path
package qtpa_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int IQ_DEPTH = 8;

endpackage

// File: rtl/iq_fifo_mem.sv
// rtl/iq_fifo_mem.sv - issue queue storage, synchronous write, asynchronous read
module iq_fifo_mem
  import qtpa_pkg::*;
#(
  parameter int DEPTH       = IQ_DEPTH,
  parameter int INSTR_WIDTH = qtpa_pkg::INSTR_WIDTH,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [INSTR_WIDTH-1:0] rdata
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issue_queue.sv
// rtl/instr_issue_queue.sv - fetch-fed FIFO with registered issue slot; IQ_PERF_CNT_EN adds perf counters
module instr_issue_queue
  import qtpa_pkg::*;
#(
  parameter int DEPTH       = IQ_DEPTH,
  parameter int INSTR_WIDTH = qtpa_pkg::INSTR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [INSTR_WIDTH-1:0]   push_instr,
  input  logic                     stall,
  input  logic                     flush,
  output logic [INSTR_WIDTH-1:0]   instruction,
  output logic                     issue_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef IQ_PERF_CNT_EN
  ,
  output logic [31:0]              bubble_cnt,
  output logic [31:0]              full_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [INSTR_WIDTH-1:0] head_instr;
  logic                   push_fire;
  logic                   pop_fire;
  logic                   bubble;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign push_ready = !full && !flush;
  assign push_fire  = push_valid && push_ready;
  // Pop and bubble decisions use registered occupancy only: no empty bypass.
  assign pop_fire   = !stall && !flush && !empty;
  assign bubble     = !stall && !flush && empty;

  iq_fifo_mem #(
    .DEPTH       (DEPTH),
    .INSTR_WIDTH (INSTR_WIDTH),
    .AW          (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_fire),
    .waddr (wr_ptr),
    .wdata (push_instr),
    .raddr (rd_ptr),
    .rdata (head_instr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push_fire) - CW'(pop_fire);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= INSTR_WIDTH'(NOP_INSTR);
      issue_valid <= 1'b0;
    end else if (flush || bubble) begin
      instruction <= INSTR_WIDTH'(NOP_INSTR);
      issue_valid <= 1'b0;
    end else if (pop_fire) begin
      instruction <= head_instr;
      issue_valid <= 1'b1;
    end
  end

`ifdef IQ_PERF_CNT_EN
  // Saturating counters; flush deliberately leaves them intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      full_cnt   <= '0;
    end else begin
      if (bubble && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
      if (push_valid && full && (full_cnt != '1)) begin
        full_cnt <= full_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// tb/tb_instr_issue_queue.sv - scoreboard bench for instr_issue_queue
module tb_instr_issue_queue;

  localparam int DEPTH = 8;
  localparam int IW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [IW-1:0] push_instr = '0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [IW-1:0] instruction;
  logic          issue_valid;
  logic [3:0]    count;
  logic          full;
  logic          empty;
`ifdef IQ_PERF_CNT_EN
  logic [31:0]   bubble_cnt;
  logic [31:0]   full_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [IW-1:0] exp_q[$];

  always #5 clk = ~clk;

  instr_issue_queue #(.DEPTH(DEPTH), .INSTR_WIDTH(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .push_instr  (push_instr),
    .stall       (stall),
    .flush       (flush),
    .instruction (instruction),
    .issue_valid (issue_valid),
    .count       (count),
    .full        (full),
    .empty       (empty)
`ifdef IQ_PERF_CNT_EN
    ,
    .bubble_cnt  (bubble_cnt),
    .full_cnt    (full_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a fresh issue is any non-stalled, non-flush edge leaving issue_valid high.
  initial begin
    logic s, f, r;
    forever begin
      @(posedge clk);
      s = stall;
      f = flush;
      r = rst;
      #1;
      if (!r && !rst && !s && !f && issue_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_issue: got %h, expected no issue", instruction);
        end else begin
          logic [IW-1:0] e;
          e = exp_q.pop_front();
          if (instruction !== e) begin
            miscompares++;
            $display("FAIL issue_order: got %h, expected %h", instruction, e);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    push_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int mcnt;
    logic do_push, do_stall, do_pop;
    int pushed;

    // Reset and idle
    do_reset();
    repeat (3) tick();
    check("reset_instr", instruction, 32'h0);
    check("reset_valid", {31'b0, issue_valid}, 32'd0);
    check("reset_empty", {31'b0, empty}, 32'd1);
    check("reset_push_ready", {31'b0, push_ready}, 32'd1);
    check("reset_count", {28'b0, count}, 32'd0);
    check("reset_full", {31'b0, full}, 32'd0);

    // Two back-to-back pushes: one edge of latency, then a bubble
    push_valid = 1'b1;
    push_instr = 32'hA000_0001;
    exp_q.push_back(32'hA000_0001);
    tick();
    check("no_bypass_valid", {31'b0, issue_valid}, 32'd0);
    push_instr = 32'hA000_0002;
    exp_q.push_back(32'hA000_0002);
    tick();
    push_valid = 1'b0;
    check("lat_a1", instruction, 32'hA000_0001);
    tick();
    check("lat_a2", instruction, 32'hA000_0002);
    tick();
    check("bubble_instr", instruction, 32'h0);
    check("bubble_valid", {31'b0, issue_valid}, 32'd0);

    // Fill to full under stall, reject a 9th push, then drain
    stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      push_valid = 1'b1;
      push_instr = 32'hB000_0000 + i;
      exp_q.push_back(32'hB000_0000 + i);
      tick();
    end
    check("full_flag", {31'b0, full}, 32'd1);
    check("full_push_ready", {31'b0, push_ready}, 32'd0);
    check("full_count", {28'b0, count}, 32'd8);
    push_instr = 32'hDEAD_BEEF;
    tick();
    check("full_reject_count", {28'b0, count}, 32'd8);
    push_valid = 1'b0;
    stall = 1'b0;
    repeat (DEPTH) tick();
    check("drain_empty", {31'b0, empty}, 32'd1);
    tick();
    check("drain_bubble", {31'b0, issue_valid}, 32'd0);

    // Wrap-around stream: 20 pushes, stall every 4th cycle
    mcnt = 0;
    pushed = 0;
    for (int c = 0; c < 30; c++) begin
      do_push  = (pushed < 20) && (mcnt < DEPTH);
      do_stall = (c % 4 == 3);
      do_pop   = !do_stall && (mcnt > 0);
      push_valid = do_push;
      push_instr = 32'hC000_0000 + pushed;
      stall = do_stall;
      if (do_push) begin
        exp_q.push_back(32'hC000_0000 + pushed);
        pushed++;
      end
      tick();
      mcnt = mcnt + int'(do_push) - int'(do_pop);
      check("wrap_count", {28'b0, count}, mcnt);
    end
    push_valid = 1'b0;
    stall = 1'b0;
    repeat (3) tick();
    check("wrap_drained", exp_q.size(), 32'd0);

    // Flush with 5 queued and a valid slot; the offered word must never issue
    push_valid = 1'b1;
    push_instr = 32'hE000_0000;
    exp_q.push_back(32'hE000_0000);
    tick();
    push_valid = 1'b0;
    tick();
    check("pre_flush_valid", {31'b0, issue_valid}, 32'd1);
    stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push_valid = 1'b1;
      push_instr = 32'hE000_0000 + i;
      tick();
    end
    check("pre_flush_count", {28'b0, count}, 32'd5);
    flush = 1'b1;
    push_instr = 32'hF000_000D;
    #1;
    check("flush_push_ready", {31'b0, push_ready}, 32'd0);
    tick();
    flush = 1'b0;
    push_valid = 1'b0;
    check("flush_count", {28'b0, count}, 32'd0);
    check("flush_valid", {31'b0, issue_valid}, 32'd0);
    check("flush_instr", instruction, 32'h0);
    stall = 1'b0;
    repeat (4) tick();
    check("post_flush_empty", {31'b0, empty}, 32'd1);

`ifdef IQ_PERF_CNT_EN
    do_reset();
    repeat (4) tick();
    stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      push_valid = 1'b1;
      push_instr = 32'h9000_0000 + i;
      tick();
    end
    repeat (3) tick();
    push_valid = 1'b0;
    check("bubble_cnt", bubble_cnt, 32'd4);
    check("full_cnt", full_cnt, 32'd3);
    do_reset();
    check("bubble_cnt_rst", bubble_cnt, 32'd0);
    check("full_cnt_rst", full_cnt, 32'd0);
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
